// File: rtl/multi_channel_signature_analyzer.sv
// multi_channel_signature_analyzer
// Compresses up to CHANNELS pixel streams per clock into one MISR signature,
// counts absorbed samples (saturating) and freezes the result at frame end.
// Optional golden comparison is built when SA_GOLDEN_COMPARE_EN is defined;
// without it pass_o/fail_o stay 0 and golden_i is unused.
module multi_channel_signature_analyzer #(
  parameter int unsigned           DATA_W   = 8,
  parameter int unsigned           CHANNELS = 2,
  parameter int unsigned           SIG_W    = 24,
  parameter logic [SIG_W-1:0]      POLY     = 24'h800057,
  parameter logic [SIG_W-1:0]      SEED     = '0,
  parameter int unsigned           COUNT_W  = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         en_i,
  input  logic                         clear_i,
  input  logic [CHANNELS-1:0]          rdy_i,
  input  logic [CHANNELS*DATA_W-1:0]   data_i,
  input  logic                         frame_done_i,
  input  logic [SIG_W-1:0]             golden_i,
  output logic [SIG_W-1:0]             signature_o,
  output logic                         sig_valid_o,
  output logic [COUNT_W-1:0]           sample_count_o,
  output logic                         pass_o,
  output logic                         fail_o
);

  localparam int unsigned POP_W = $clog2(CHANNELS + 1);
  localparam int unsigned SUM_W = COUNT_W + POP_W;
  localparam logic [SUM_W-1:0] SUM_CAP = SUM_W'({COUNT_W{1'b1}});

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SIG_W-1:0]     sig_q, sig_d, sig_chain;
  logic [COUNT_W-1:0]   cnt_q, cnt_d, cnt_next;
  logic [POP_W-1:0]     pop;
  logic [SUM_W-1:0]     cnt_sum;
  logic                 valid_q, valid_d;
  logic                 pass_q, pass_d;
  logic                 fail_q, fail_d;
  logic                 absorb;
  logic                 done_entry;

  // One MISR step: shift in tap parity, then fold in the zero-extended sample.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic [DATA_W-1:0] d);
    logic fb;
    fb = ^(s & POLY);
    return {s[SIG_W-2:0], fb} ^ SIG_W'(d);
  endfunction

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; clear wins everywhere, dropping enable pauses in IDLE.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (en_i) state_d = ACCUM;
        ACCUM: begin
          if (!en_i)             state_d = IDLE;
          else if (frame_done_i) state_d = DONE;
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Chained absorption of valid channels in ascending order plus popcount.
  always_comb begin
    sig_chain = sig_q;
    pop       = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (rdy_i[k]) begin
        sig_chain = misr_step(sig_chain, data_i[k*DATA_W +: DATA_W]);
        pop       = pop + POP_W'(1);
      end
    end
  end

  // Saturating sample counter increment.
  always_comb begin
    cnt_sum  = SUM_W'(cnt_q) + SUM_W'(pop);
    cnt_next = (cnt_sum > SUM_CAP) ? {COUNT_W{1'b1}} : cnt_sum[COUNT_W-1:0];
  end

  // Output/datapath next values; samples only enter while enabled in ACCUM.
  always_comb begin
    absorb     = (state_q == ACCUM) && en_i && !clear_i;
    done_entry = absorb && frame_done_i;
    sig_d      = sig_q;
    cnt_d      = cnt_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    valid_d    = (state_d == DONE);
    if (clear_i) begin
      sig_d  = SEED;
      cnt_d  = '0;
      pass_d = 1'b0;
      fail_d = 1'b0;
    end else if (absorb) begin
      sig_d = sig_chain;
      cnt_d = cnt_next;
`ifdef SA_GOLDEN_COMPARE_EN
      if (done_entry) begin
        pass_d = (sig_chain == golden_i);
        fail_d = (sig_chain != golden_i);
      end
`endif
    end
  end

`ifndef SA_GOLDEN_COMPARE_EN
  logic unused_golden;
  assign unused_golden = ^golden_i;
`endif

  // Registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sig_q   <= SEED;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign signature_o    = sig_q;
  assign sample_count_o = cnt_q;
  assign sig_valid_o    = valid_q;
  assign pass_o         = pass_q;
  assign fail_o         = fail_q;

endmodule

// File: tb/tb_multi_channel_signature_analyzer.sv
// Scoreboard bench for multi_channel_signature_analyzer (default parameters
// plus a COUNT_W=4 instance sharing the same stimulus for saturation).
module tb_multi_channel_signature_analyzer;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, clear, frame_done;
  logic [1:0]  rdy;
  logic [15:0] data;
  logic [23:0] golden;

  logic [23:0] sig, s_sig;
  logic [15:0] cnt;
  logic [3:0]  s_cnt;
  logic        valid, pass, fail, s_valid, s_pass, s_fail;

  always #5 clk = ~clk;

  multi_channel_signature_analyzer u_dut (
    .clk_i(clk), .reset_i(reset), .en_i(en), .clear_i(clear), .rdy_i(rdy),
    .data_i(data), .frame_done_i(frame_done), .golden_i(golden),
    .signature_o(sig), .sig_valid_o(valid), .sample_count_o(cnt),
    .pass_o(pass), .fail_o(fail)
  );

  multi_channel_signature_analyzer #(.COUNT_W(4)) u_sat (
    .clk_i(clk), .reset_i(reset), .en_i(en), .clear_i(clear), .rdy_i(rdy),
    .data_i(data), .frame_done_i(frame_done), .golden_i(golden),
    .signature_o(s_sig), .sig_valid_o(s_valid), .sample_count_o(s_cnt),
    .pass_o(s_pass), .fail_o(s_fail)
  );

  typedef struct {
    int          id;
    logic [23:0] sig;
    logic [15:0] cnt;
    logic [3:0]  scnt;
    logic        sv;
    logic        ps;
    logic        fl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  // Reference model state
  logic [23:0] m_sig;
  int          m_cnt;
  int          m_state;   // 0 idle, 1 accum, 2 done
  logic        m_pass, m_fail;

  function automatic logic [23:0] mstep(input logic [23:0] s, input logic [7:0] d);
    logic fb;
    fb = ^(s & 24'h800057);
    return {s[22:0], fb} ^ {16'h0000, d};
  endfunction

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, id, act, expv);
    end
  endtask

  task automatic model_reset();
    m_sig = 24'h0; m_cnt = 0; m_state = 0; m_pass = 1'b0; m_fail = 1'b0;
  endtask

  // Drive one cycle of inputs and push the expected post-edge outputs.
  task automatic step(input logic e, input logic c, input logic [1:0] r,
                      input logic [7:0] d0, input logic [7:0] d1, input logic fd,
                      input logic [23:0] gold, input logic hand,
                      input logic [23:0] hand_sig);
    exp_t x;
    @(negedge clk);
    en = e; clear = c; rdy = r; data = {d1, d0}; frame_done = fd; golden = gold;
    if (c) begin
      model_reset();
    end else if (m_state == 0) begin
      if (e) m_state = 1;
    end else if (m_state == 1) begin
      if (!e) m_state = 0;
      else begin
        if (r[0]) begin m_sig = mstep(m_sig, d0); m_cnt++; end
        if (r[1]) begin m_sig = mstep(m_sig, d1); m_cnt++; end
        if (m_cnt > 65535) m_cnt = 65535;
        if (fd) begin
          m_state = 2;
`ifdef SA_GOLDEN_COMPARE_EN
          m_pass = (m_sig == gold);
          m_fail = (m_sig != gold);
`endif
        end
      end
    end
    if (hand) m_sig = hand_sig;
    step_id++;
    x.id   = step_id;
    x.sig  = m_sig;
    x.cnt  = 16'(m_cnt);
    x.scnt = (m_cnt > 15) ? 4'd15 : 4'(m_cnt);
    x.sv   = (m_state == 2);
    x.ps   = m_pass;
    x.fl   = m_fail;
    exp_q.push_back(x);
  endtask

  // Monitor: one expectation per edge, sampled well after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("signature",    x.id, 32'(sig),     32'(x.sig));
        chk("count",        x.id, 32'(cnt),     32'(x.cnt));
        chk("sig_valid",    x.id, 32'(valid),   32'(x.sv));
        chk("pass",         x.id, 32'(pass),    32'(x.ps));
        chk("fail",         x.id, 32'(fail),    32'(x.fl));
        chk("sat_count",    x.id, 32'(s_cnt),   32'(x.scnt));
        chk("sat_signature",x.id, 32'(s_sig),   32'(x.sig));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    reset = 1'b1; en = 1'b0; clear = 1'b0; rdy = 2'b00; data = 16'h0;
    frame_done = 1'b0; golden = 24'h0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_sig",   0, 32'(sig),   32'h0);
    chk("reset_cnt",   0, 32'(cnt),   32'h0);
    chk("reset_valid", 0, 32'(valid), 32'h0);
    chk("reset_pass",  0, 32'(pass),  32'h0);
    chk("reset_fail",  0, 32'(fail),  32'h0);
    reset = 1'b0;

    // Serial stream
    step(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 24'h0, 1'b1, 24'h000000);
    step(1'b1, 1'b0, 2'b01, 8'hEE, 8'h00, 1'b0, 24'h0, 1'b1, 24'h000000); // transition, no absorb
    step(1'b1, 1'b0, 2'b01, 8'h5A, 8'h00, 1'b0, 24'h0, 1'b1, 24'h00005A);
    step(1'b1, 1'b0, 2'b01, 8'h01, 8'h00, 1'b0, 24'h0, 1'b1, 24'h0000B4);
    // Clear with both channels valid
    step(1'b1, 1'b1, 2'b11, 8'h33, 8'h44, 1'b1, 24'h0, 1'b1, 24'h000000);
    // Parallel stream
    step(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 24'h0, 1'b1, 24'h000000);
    step(1'b1, 1'b0, 2'b11, 8'h5A, 8'h01, 1'b0, 24'h0, 1'b1, 24'h0000B4);
    // Frame end with ch1-only sample; golden matches final value
    step(1'b1, 1'b0, 2'b10, 8'hFF, 8'h01, 1'b1, 24'h000169, 1'b1, 24'h000169);
    // DONE ignores further samples
    step(1'b1, 1'b0, 2'b11, 8'h12, 8'h34, 1'b1, 24'h0, 1'b1, 24'h000169);
    step(1'b0, 1'b0, 2'b01, 8'h77, 8'h00, 1'b0, 24'h0, 1'b1, 24'h000169);
    // Golden mismatch
    step(1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 24'h0, 1'b1, 24'h000000);
    step(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 24'h0, 1'b1, 24'h000000);
    step(1'b1, 1'b0, 2'b01, 8'h5A, 8'h00, 1'b0, 24'h0, 1'b1, 24'h00005A);
    step(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 24'h000000, 1'b1, 24'h00005A);
    // frame_done in IDLE ignored
    step(1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 24'h0, 1'b1, 24'h000000);
    step(1'b0, 1'b0, 2'b11, 8'h11, 8'h22, 1'b1, 24'h0, 1'b1, 24'h000000);
    // Pause and resume
    step(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 24'h0, 1'b1, 24'h000000);
    step(1'b1, 1'b0, 2'b01, 8'h5A, 8'h00, 1'b0, 24'h0, 1'b1, 24'h00005A);
    step(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 24'h0, 1'b1, 24'h00005A);
    step(1'b1, 1'b0, 2'b01, 8'hFF, 8'h00, 1'b0, 24'h0, 1'b1, 24'h00005A);
    step(1'b1, 1'b0, 2'b01, 8'h01, 8'h00, 1'b0, 24'h0, 1'b1, 24'h0000B4);
    // Saturation: 20 single-channel samples
    step(1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 24'h0, 1'b1, 24'h000000);
    step(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 24'h0, 1'b0, 24'h0);
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b0, 2'b01, 8'(i * 7 + 3), 8'h00, 1'b0, 24'h0, 1'b0, 24'h0);
    step(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 24'h0, 1'b0, 24'h0);

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
    end
    chk("done_before_reset", 0, 32'(valid), 32'h1);

    // Async reset while in DONE, checked before the next edge
    @(negedge clk);
    en = 1'b0; rdy = 2'b00; frame_done = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("areset_sig",   0, 32'(sig),   32'h0);
    chk("areset_cnt",   0, 32'(cnt),   32'h0);
    chk("areset_valid", 0, 32'(valid), 32'h0);
    chk("areset_pass",  0, 32'(pass),  32'h0);
    chk("areset_fail",  0, 32'(fail),  32'h0);
    chk("areset_scnt",  0, 32'(s_cnt), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
